data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed, little-endian data memory for the CPU's MEM stage.
- Replaces the combinational word-only memory with:
  - a synchronous, clocked write path
  - byte, half and word access with sign or zero extension on loads
  - a configurable read latency with a ready/valid handshake
  - alignment error reporting
  - a hardware clear sequence after reset
- Sits between the ALU address output and the write-back mux.

Parameters:
- ADDR_W, 8: byte address width. Memory holds 2^ADDR_W bytes. Must be ≥ 2.
- READ_LAT, 1: read latency in cycles, from request acceptance to M_R_Valid. Legal range 1..4.

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Mem_Req  in  1  access request; qualified by Mem_Ready
- Mem_Write  in  1  1 = store, 0 = load
- Mem_Addr  in  ADDR_W  byte address
- Mem_Size  in  2  00 byte, 01 half, 10 word, 11 reserved
- Mem_Unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for word accesses
- M_W_Data  in  32  store data; the low-order bytes are used for byte and half stores
- Mem_Ready  out  1  block can accept a request this cycle
- M_R_Data  out  32  load result, extended to 32 bits
- M_R_Valid  out  1  one-cycle pulse; M_R_Data is valid while it is high
- Mem_Err  out  1  one-cycle pulse; the accepted request was misaligned or used a reserved size
- Init_Busy  out  1  clear sequence in progress

Behaviour:

Reset values:
- Reset asserted, at any time including mid-read: FSM goes to INIT, clear counter is 0.
- Outputs: Mem_Ready=0, M_R_Valid=0, Mem_Err=0, M_R_Data=0, Init_Busy=1.
- A pending read is discarded and never produces M_R_Valid.

FSM states: INIT, IDLE, RD_WAIT.
- INIT
  - Each cycle, writes 0 to one aligned 4-byte word at index = counter, then increments the counter.
  - After 2^(ADDR_W-2) cycles, goes to IDLE; Init_Busy falls on that same edge.
  - Mem_Ready=0; Mem_Req is ignored.
- IDLE
  - Mem_Ready=1.
  - A request is accepted on edge N when Mem_Req=1 and Mem_Ready=1.
- Alignment rule:
  - Legal: byte at any address; half with Mem_Addr[0]=0; word with Mem_Addr[1:0]=0.
  - Illegal: every other combination, including Mem_Size=11.
  - Because accesses are aligned, an access never crosses the top of memory; no wrap handling is needed.
- Illegal request:
  - Memory is unchanged, no M_R_Valid.
  - Mem_Err=1 for the single cycle after edge N; FSM stays in IDLE.
- Legal store:
  - The selected bytes are written on edge N, little-endian:
    - M_W_Data[7:0] goes to Mem_Addr.
    - M_W_Data[15:8] goes to Mem_Addr+1, and so on.
  - Unselected bytes are untouched. No M_R_Valid. FSM stays in IDLE.
- Legal load:
  - Memory is snapshotted on edge N. A store accepted on edge N+1 does not affect the returned data.
  - Extension: byte extends bit 7, half extends bit 15, unless Mem_Unsigned=1 (then zero-extend).
  - READ_LAT=1: M_R_Data is loaded and M_R_Valid=1 for the cycle after edge N. Mem_Ready stays 1, so back-to-back loads give one result per cycle.
  - READ_LAT>1: FSM goes to RD_WAIT with Mem_Ready=0 and a down-counter.
    - M_R_Valid pulses for the cycle after edge N+READ_LAT-1.
    - On that same edge the FSM returns to IDLE, so the next request can be accepted on edge N+READ_LAT.
- M_R_Data holds its last valid value until the next M_R_Valid; it is not cleared between loads.
- Mem_Write and Mem_Unsigned are don't-care when Mem_Req=0.
- M_R_Valid and Mem_Err are never high in the same cycle.

Test Plan:
1. Clear sequence. Assert Reset, release it, ADDR_W=8. Check:
   - Init_Busy=1 and Mem_Ready=0 for exactly 64 cycles, then Ready=1.
   - A word load from 0xFC returns 0x00000000.
2. Store then narrow loads. Word store 0x80FF7F01 to 0x10. Then:
   - byte-signed load @0x13 → 0xFFFFFF80
   - byte-unsigned load @0x13 → 0x00000080
   - half-signed load @0x12 → 0xFFFF80FF
   - half-unsigned load @0x10 → 0x00007F01
3. Partial store. Word store 0x11223344 to 0x20, then byte store 0xAB to 0x21. Word load @0x20 → 0x1122AB44.
4. Alignment errors:
   - half load @0x05 → Mem_Err pulse 1 cycle, no M_R_Valid
   - word store @0x22 → Mem_Err pulse, memory unchanged
   - Mem_Size=11 → Mem_Err pulse
5. Read latency, READ_LAT=3. Issue back-to-back requests (load, then store to the same address). Check:
   - M_R_Valid on the cycle after edge N+2.
   - Mem_Ready=0 during the wait.
   - The store is accepted on edge N+3.
   - The load returns the old data.
6. Reset mid-read, READ_LAT=4. Assert Reset 2 cycles after acceptance. Check:
   - No M_R_Valid is ever produced.
   - M_R_Data=0.
   - INIT restarts and earlier stored data reads back 0.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Byte-addressed, little-endian data memory for the MEM stage: clocked stores, sized loads with
// sign/zero extension, configurable read latency and a word-per-cycle clear sweep after reset.
module data_memory_ctrl #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned READ_LAT = 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Mem_Req,
   input  logic              Mem_Write,
   input  logic [ADDR_W-1:0] Mem_Addr,
   input  logic [1:0]        Mem_Size,
   input  logic              Mem_Unsigned,
   input  logic [31:0]       M_W_Data,
   output logic              Mem_Ready,
   output logic [31:0]       M_R_Data,
   output logic              M_R_Valid,
   output logic              Mem_Err,
   output logic              Init_Busy
);

   localparam int unsigned     Words   = 2 ** (ADDR_W - 2);
   localparam int unsigned     IdxW    = (ADDR_W > 2) ? ADDR_W - 2 : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);
   localparam logic [2:0]      LatInit = 3'(READ_LAT - 1);

   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;

   typedef enum logic [1:0] {StInit, StIdle, StRdWait} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] clr_cnt_q, clr_cnt_d;
   logic [2:0]      lat_cnt_q, lat_cnt_d;
   logic [31:0]     pend_q, pend_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic [31:0]     mem_q [Words];

   logic [IdxW-1:0] word_idx;
   logic [31:0]     rd_word;
   logic [31:0]     rd_lane;
   logic [31:0]     ld_data;
   logic [3:0]      wr_be;
   logic [31:0]     wr_lane;
   logic            addr_ok;
   logic            accept;
   logic            store_en;

   if (ADDR_W > 2) begin : g_idx_wide
      assign word_idx = Mem_Addr[ADDR_W-1:2];
   end else begin : g_idx_single
      assign word_idx = 1'b0;
   end

   assign rd_word  = mem_q[word_idx];
   assign accept   = (state_q == StIdle) & Mem_Req;
   assign store_en = accept & addr_ok & Mem_Write;

   // Load path: move the addressed lane to bit 0, then extend from its top bit.
   always_comb begin
      rd_lane = rd_word >> {Mem_Addr[1:0], 3'b000};
      case (Mem_Size)
         SzByte:  ld_data = {{24{rd_lane[7] & ~Mem_Unsigned}}, rd_lane[7:0]};
         SzHalf:  ld_data = {{16{rd_lane[15] & ~Mem_Unsigned}}, rd_lane[15:0]};
         default: ld_data = rd_lane;
      endcase
   end

   // Store path: replicate the low-order data across lanes and enable only the addressed bytes.
   always_comb begin
      wr_be   = 4'b0000;
      wr_lane = M_W_Data;
      addr_ok = 1'b0;
      case (Mem_Size)
         SzByte: begin
            addr_ok = 1'b1;
            wr_be   = 4'b0001 << Mem_Addr[1:0];
            wr_lane = {4{M_W_Data[7:0]}};
         end
         SzHalf: begin
            addr_ok = ~Mem_Addr[0];
            wr_be   = 4'b0011 << {Mem_Addr[1], 1'b0};
            wr_lane = {2{M_W_Data[15:0]}};
         end
         SzWord: begin
            addr_ok = (Mem_Addr[1:0] == 2'b00);
            wr_be   = 4'b1111;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      lat_cnt_d = lat_cnt_q;
      pend_d    = pend_q;
      rdata_d   = rdata_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StInit: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LastIdx) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (accept) begin
               if (!addr_ok) begin
                  err_d = 1'b1;
               end else if (!Mem_Write) begin
                  if (READ_LAT <= 1) begin
                     rdata_d = ld_data;
                     valid_d = 1'b1;
                  end else begin
                     // Snapshot now so a store accepted behind this load cannot leak in.
                     pend_d    = ld_data;
                     lat_cnt_d = LatInit;
                     state_d   = StRdWait;
                  end
               end
            end
         end
         StRdWait: begin
            lat_cnt_d = lat_cnt_q - 1'b1;
            if (lat_cnt_q == 3'd1) begin
               rdata_d = pend_q;
               valid_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q   <= StInit;
         clr_cnt_q <= '0;
         lat_cnt_q <= '0;
         pend_q    <= '0;
         rdata_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         lat_cnt_q <= lat_cnt_d;
         pend_q    <= pend_d;
         rdata_q   <= rdata_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   // Storage array carries no reset; the clear sweep initialises it.
   always_ff @(posedge CLK) begin
      if (state_q == StInit) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (store_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem_q[word_idx][8*i +: 8] <= wr_lane[8*i +: 8];
            end
         end
      end
   end

   assign Mem_Ready = (state_q == StIdle);
   assign Init_Busy = (state_q == StInit);
   assign M_R_Data  = rdata_q;
   assign M_R_Valid = valid_q;
   assign Mem_Err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three instances (READ_LAT 1, 3, 4) checked against a byte-array
// reference model with directed scenarios and randomized accesses.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic        req   [3];
   logic        wr    [3];
   logic [7:0]  addr  [3];
   logic [1:0]  size  [3];
   logic        uns   [3];
   logic [31:0] wd    [3];
   logic        rdy   [3];
   logic [31:0] rdata [3];
   logic        vld   [3];
   logic        err   [3];
   logic        busy  [3];

   int lat_of [3] = '{1, 3, 4};
   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mdl [3][256];
   logic [31:0] last_data [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_memory_ctrl #(
         .ADDR_W   (8),
         .READ_LAT ((g == 0) ? 1 : (g == 1) ? 3 : 4)
      ) u_dut (
         .CLK          (clk),
         .Reset        (rst[g]),
         .Mem_Req      (req[g]),
         .Mem_Write    (wr[g]),
         .Mem_Addr     (addr[g]),
         .Mem_Size     (size[g]),
         .Mem_Unsigned (uns[g]),
         .M_W_Data     (wd[g]),
         .Mem_Ready    (rdy[g]),
         .M_R_Data     (rdata[g]),
         .M_R_Valid    (vld[g]),
         .Mem_Err      (err[g]),
         .Init_Busy    (busy[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic bit is_legal(input logic [1:0] s, input logic [7:0] a);
      return (s == 2'd0) || (s == 2'd1 && a % 2 == 0) || (s == 2'd2 && a % 4 == 0);
   endfunction

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   task automatic mdl_clear(input int d);
      for (int i = 0; i < 256; i++) mdl[d][i] = 8'h00;
      last_data[d] = 32'h0;
   endtask

   // Predicts what one isolated access should show: packed {valid count, valid cycle, error
   // count, error cycle, ready-low cycles} and the M_R_Data value at the end of the window.
   task automatic predict(input int d, input bit w, input logic [1:0] s, input bit u,
                          input logic [7:0] a, input logic [31:0] wdv,
                          output logic [39:0] esig, output logic [31:0] edat);
      int n;
      logic [31:0] v;
      n = nbytes(s);
      if (!is_legal(s, a)) begin
         esig = {8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
         edat = last_data[d];
      end else if (w) begin
         for (int i = 0; i < n; i++) mdl[d][int'(a) + i] = 8'((wdv >> (8 * i)) & 32'hFF);
         esig = '0;
         edat = last_data[d];
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = v | (32'(mdl[d][int'(a) + i]) << (8 * i));
         if (!u && n == 1 && v >= 32'h80)   v = v + 32'hFFFFFF00;
         if (!u && n == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
         last_data[d] = v;
         esig = {8'd1, 8'(lat_of[d] - 1), 8'd0, 8'd0, 8'(lat_of[d] - 1)};
         edat = v;
      end
   endtask

   // ---------------- stimulus driver (observes, does not judge) ----------------
   task automatic access(input int d, input bit w, input logic [1:0] s, input bit u,
                         input logic [7:0] a, input logic [31:0] wdv,
                         output logic [39:0] osig, output logic [31:0] odat);
      int vcnt = 0, vcyc = 0, ecnt = 0, ecyc = 0, rlow = 0;
      bit got = 0;
      req[d] = 1'b1; wr[d] = w; size[d] = s; uns[d] = u; addr[d] = a; wd[d] = wdv;
      @(posedge clk);
      #1 req[d] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (vld[d]) begin vcnt++; vcyc = k; odat = rdata[d]; got = 1; end
         if (err[d]) begin ecnt++; ecyc = k; end
         if (!rdy[d]) rlow++;
      end
      if (!got) odat = rdata[d];
      osig = {8'(vcnt), 8'(vcyc), 8'(ecnt), 8'(ecyc), 8'(rlow)};
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset(input int d);
      int cyc = 0, rbad = 0;
      logic [39:0] es, os;
      logic [31:0] ed, od;
      rst[d] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({rdy[d], vld[d], err[d], busy[d], rdata[d]} !== {4'b0001, 32'h0}) begin
         n_bad++;
         $display("FAIL reset_values[%0d]: got rdy=%b vld=%b err=%b busy=%b data=%h, want 0 0 0 1 0",
                  d, rdy[d], vld[d], err[d], busy[d], rdata[d]);
      end
      rst[d] = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (!busy[d]) break;
         if (rdy[d]) rbad++;
      end
      n_cmp++;
      if (cyc !== 64 || rbad !== 0 || rdy[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL init_length[%0d]: got busy cycles=%0d ready-while-busy=%0d ready=%b, want 64 0 1",
                  d, cyc, rbad, rdy[d]);
      end
      mdl_clear(d);
      predict(d, 0, 2'd2, 0, 8'hFC, 32'h0, es, ed);
      access(d, 0, 2'd2, 0, 8'hFC, 32'h0, os, od);
      n_cmp++;
      if ({os, od} !== {es, 32'h0000_0000}) begin
         n_bad++;
         $display("FAIL init_cleared[%0d]: got sig=%h data=%h, want sig=%h data=00000000",
                  d, os, od, es);
      end
   endtask

   task automatic test_store_narrow();
      logic [39:0] es, os;
      logic [31:0] ed, od;
      logic [7:0]  ta [4];
      logic [1:0]  ts [4];
      bit          tu [4];
      logic [31:0] tv [4];
      ta[0] = 8'h13; ts[0] = 2'd0; tu[0] = 0; tv[0] = 32'hFFFF_FF80;
      ta[1] = 8'h13; ts[1] = 2'd0; tu[1] = 1; tv[1] = 32'h0000_0080;
      ta[2] = 8'h12; ts[2] = 2'd1; tu[2] = 0; tv[2] = 32'hFFFF_80FF;
      ta[3] = 8'h10; ts[3] = 2'd1; tu[3] = 1; tv[3] = 32'h0000_7F01;
      predict(0, 1, 2'd2, 0, 8'h10, 32'h80FF_7F01, es, ed);
      access(0, 1, 2'd2, 0, 8'h10, 32'h80FF_7F01, os, od);
      n_cmp++;
      if ({os, od} !== {es, ed}) begin
         n_bad++;
         $display("FAIL word_store: got sig=%h data=%h, want sig=%h data=%h", os, od, es, ed);
      end
      for (int i = 0; i < 4; i++) begin
         predict(0, 0, ts[i], tu[i], ta[i], 32'h0, es, ed);
         access(0, 0, ts[i], tu[i], ta[i], 32'h0, os, od);
         n_cmp++;
         if ({os, od} !== {es, tv[i]}) begin
            n_bad++;
            $display("FAIL narrow_load[%0d] @%h: got sig=%h data=%h, want sig=%h data=%h",
                     i, ta[i], os, od, es, tv[i]);
         end
      end
   endtask

   task automatic test_partial_store();
      logic [39:0] es, os;
      logic [31:0] ed, od;
      predict(0, 1, 2'd2, 0, 8'h20, 32'h1122_3344, es, ed);
      access(0, 1, 2'd2, 0, 8'h20, 32'h1122_3344, os, od);
      predict(0, 1, 2'd0, 0, 8'h21, 32'hDEAD_BEAB, es, ed);
      access(0, 1, 2'd0, 0, 8'h21, 32'hDEAD_BEAB, os, od);
      n_cmp++;
      if (os !== es) begin
         n_bad++;
         $display("FAIL byte_store: got sig=%h, want sig=%h", os, es);
      end
      predict(0, 0, 2'd2, 0, 8'h20, 32'h0, es, ed);
      access(0, 0, 2'd2, 0, 8'h20, 32'h0, os, od);
      n_cmp++;
      if ({os, od} !== {es, 32'h1122_AB44}) begin
         n_bad++;
         $display("FAIL partial_store: got sig=%h data=%h, want sig=%h data=1122ab44", os, od, es);
      end
   endtask

   task automatic test_align_err();
      logic [39:0] es, os;
      logic [31:0] ed, od;
      bit          tw [4];
      logic [1:0]  ts [4];
      logic [7:0]  ta [4];
      tw[0] = 0; ts[0] = 2'd1; ta[0] = 8'h05;
      tw[1] = 1; ts[1] = 2'd2; ta[1] = 8'h22;
      tw[2] = 0; ts[2] = 2'd3; ta[2] = 8'h00;
      tw[3] = 1; ts[3] = 2'd3; ta[3] = 8'h20;
      for (int i = 0; i < 4; i++) begin
         predict(0, tw[i], ts[i], 0, ta[i], 32'hFFFF_FFFF, es, ed);
         access(0, tw[i], ts[i], 0, ta[i], 32'hFFFF_FFFF, os, od);
         n_cmp++;
         if ({os, od} !== {es, ed}) begin
            n_bad++;
            $display("FAIL align_err[%0d] size=%0d @%h: got sig=%h data=%h, want sig=%h data=%h",
                     i, ts[i], ta[i], os, od, es, ed);
         end
      end
      predict(0, 0, 2'd2, 0, 8'h20, 32'h0, es, ed);
      access(0, 0, 2'd2, 0, 8'h20, 32'h0, os, od);
      n_cmp++;
      if ({os, od} !== {es, 32'h1122_AB44}) begin
         n_bad++;
         $display("FAIL err_no_write: got sig=%h data=%h, want sig=%h data=1122ab44", os, od, es);
      end
   endtask

   // Requests held on consecutive edges at READ_LAT=1: one result per cycle.
   task automatic test_back_to_back();
      logic [39:0] es;
      logic [31:0] ed;
      bit          tw [5];
      logic [1:0]  ts [5];
      logic [7:0]  ta [5];
      tw[0] = 0; ts[0] = 2'd2; ta[0] = 8'h10;
      tw[1] = 0; ts[1] = 2'd2; ta[1] = 8'h20;
      tw[2] = 0; ts[2] = 2'd0; ta[2] = 8'h13;
      tw[3] = 1; ts[3] = 2'd2; ta[3] = 8'h20;
      tw[4] = 0; ts[4] = 2'd2; ta[4] = 8'h20;
      for (int i = 0; i < 5; i++) begin
         req[0] = 1'b1; wr[0] = tw[i]; size[0] = ts[i]; uns[0] = 0; addr[0] = ta[i];
         wd[0] = 32'h5555_AAAA;
         predict(0, tw[i], ts[i], 0, ta[i], 32'h5555_AAAA, es, ed);
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if ({vld[0], rdy[0], err[0], rdata[0]} !== {!tw[i], 2'b10, ed}) begin
            n_bad++;
            $display("FAIL back_to_back[%0d]: got vld=%b rdy=%b err=%b data=%h, want %b 1 0 %h",
                     i, vld[0], rdy[0], err[0], rdata[0], !tw[i], ed);
         end
      end
      req[0] = 1'b0;
   endtask

   // READ_LAT=3: load then a store to the same word queued right behind it.
   task automatic test_latency();
      logic [39:0] es, os;
      logic [31:0] ed, od, prev, old_w, new_w;
      old_w = $urandom;
      new_w = ~old_w;
      predict(1, 1, 2'd2, 0, 8'h30, old_w, es, ed);
      access(1, 1, 2'd2, 0, 8'h30, old_w, os, od);
      prev = last_data[1];
      predict(1, 0, 2'd2, 0, 8'h30, 32'h0, es, ed);
      req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = 8'h30;
      @(posedge clk);
      #1 wr[1] = 1'b1; wd[1] = new_w;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({vld[1], rdy[1], err[1], rdata[1]} !== {(k == 2), (k == 2), 1'b0, (k == 2) ? ed : prev})
         begin
            n_bad++;
            $display("FAIL latency cycle %0d: got vld=%b rdy=%b err=%b data=%h, want %b %b 0 %h",
                     k, vld[1], rdy[1], err[1], rdata[1], (k == 2), (k == 2), (k == 2) ? ed : prev);
         end
      end
      @(posedge clk);
      #1 req[1] = 1'b0;
      predict(1, 1, 2'd2, 0, 8'h30, new_w, es, ed);
      @(negedge clk);
      n_cmp++;
      if ({vld[1], rdy[1], err[1], rdata[1]} !== {3'b010, ed}) begin
         n_bad++;
         $display("FAIL latency_store_accept: got vld=%b rdy=%b err=%b data=%h, want 0 1 0 %h",
                  vld[1], rdy[1], err[1], rdata[1], ed);
      end
      predict(1, 0, 2'd2, 0, 8'h30, 32'h0, es, ed);
      access(1, 0, 2'd2, 0, 8'h30, 32'h0, os, od);
      n_cmp++;
      if ({os, od} !== {es, new_w}) begin
         n_bad++;
         $display("FAIL latency_readback: got sig=%h data=%h, want sig=%h data=%h", os, od, es, new_w);
      end
   endtask

   // READ_LAT=4: reset lands while a load is in flight.
   task automatic test_reset_mid_read();
      logic [39:0] es, os;
      logic [31:0] ed, od;
      int vseen = 0, cyc = 0;
      predict(2, 1, 2'd2, 0, 8'h40, 32'hCAFE_F00D, es, ed);
      access(2, 1, 2'd2, 0, 8'h40, 32'hCAFE_F00D, os, od);
      predict(2, 0, 2'd2, 0, 8'h40, 32'h0, es, ed);
      access(2, 0, 2'd2, 0, 8'h40, 32'h0, os, od);
      n_cmp++;
      if ({os, od} !== {es, 32'hCAFE_F00D}) begin
         n_bad++;
         $display("FAIL pre_reset_load: got sig=%h data=%h, want sig=%h data=cafef00d", os, od, es);
      end
      req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'd2; addr[2] = 8'h40;
      @(posedge clk);
      #1 req[2] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (vld[2]) vseen++;
      end
      n_cmp++;
      if ({rdata[2], busy[2], rdy[2]} !== {32'h0, 2'b10}) begin
         n_bad++;
         $display("FAIL mid_read_reset: got data=%h busy=%b rdy=%b, want 00000000 1 0",
                  rdata[2], busy[2], rdy[2]);
      end
      rst[2] = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (vld[2]) vseen++;
         if (!busy[2]) break;
      end
      n_cmp++;
      if (vseen !== 0 || cyc !== 64) begin
         n_bad++;
         $display("FAIL mid_read_no_valid: got valid pulses=%0d init cycles=%0d, want 0 64", vseen, cyc);
      end
      mdl_clear(2);
      predict(2, 0, 2'd2, 0, 8'h40, 32'h0, es, ed);
      access(2, 0, 2'd2, 0, 8'h40, 32'h0, os, od);
      n_cmp++;
      if ({os, od} !== {es, 32'h0}) begin
         n_bad++;
         $display("FAIL reinit_cleared: got sig=%h data=%h, want sig=%h data=00000000", os, od, es);
      end
   endtask

   task automatic test_random(input int d, input int n);
      logic [39:0] es, os;
      logic [31:0] ed, od, wdv;
      logic [1:0]  s;
      logic [7:0]  a;
      bit          w, u;
      for (int i = 0; i < n; i++) begin
         s = 2'($urandom_range(0, 3));
         a = 8'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) begin
            if (s == 2'd1) a[0] = 1'b0;
            else if (s == 2'd2) a[1:0] = 2'b00;
         end
         w   = 1'($urandom_range(0, 1));
         u   = 1'($urandom_range(0, 1));
         wdv = $urandom;
         predict(d, w, s, u, a, wdv, es, ed);
         access(d, w, s, u, a, wdv, os, od);
         n_cmp++;
         if ({os, od} !== {es, ed}) begin
            n_bad++;
            $display("FAIL random[%0d.%0d] w=%b size=%0d uns=%b @%h wd=%h: got sig=%h data=%h, want sig=%h data=%h",
                     d, i, w, s, u, a, wdv, os, od, es, ed);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 8'h0;
         size[d] = 2'd0; uns[d] = 1'b0; wd[d] = 32'h0; last_data[d] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) test_reset(d);
      test_store_narrow();
      test_partial_store();
      test_align_err();
      test_back_to_back();
      test_random(0, 80);
      test_latency();
      test_random(1, 60);
      test_reset_mid_read();
      test_random(2, 60);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
